muldiv_iterative: RTL

//   Multi-cycle unsigned multiply/divide unit for miniRV (M-lite: MUL, MULHU, DIVU, REMU).

---
 rtl/muldiv_iterative.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/muldiv_iterative.sv
// muldiv_iterative: multi-cycle unsigned MUL/MULHU/DIVU/REMU unit.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle.
// A single 2*XLEN accumulator holds either the running product
// {upper, multiplier} or the division pair {remainder, quotient}.
// In both cases the low half is the MUL/DIVU answer and the high half is
// the MULHU/REMU answer, so op[0] alone picks the result half.
module muldiv_iterative #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [XLEN-1:0]   rs1_val,
   input  logic [XLEN-1:0]   rs2_val,
   input  logic [ADDR_W-1:0] rd_addr_in,
   output logic              busy,
   output logic              reg_write,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]   rd_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          op_q, op_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [ADDR_W-1:0]   dest_q, dest_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]     rd_data_q, rd_data_d;
   logic                busy_q, busy_d;
   logic                reg_write_q, reg_write_d;

   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN:0]       div_shift;
   logic [XLEN-1:0]     div_diff;
   logic                div_fits;
   logic [2*XLEN-1:0]   div_next;
   logic [XLEN-1:0]     dbz_result;
   logic                dbz;

   // One iteration of each algorithm, computed from the current accumulator.
   // The remainder before a step is always below the divisor, so the
   // difference after a successful compare fits in XLEN bits.
   always_comb begin
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]};
      if (acc_q[0]) begin
         mul_sum = mul_sum + {1'b0, opb_q};
      end
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};

      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_fits  = (div_shift >= {1'b0, opb_q});
      div_diff  = div_shift[XLEN-1:0] - opb_q;
      if (div_fits) begin
         div_next = {div_diff, acc_q[XLEN-2:0], 1'b1};
      end else begin
         div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end

      dbz        = op[1] && (rs2_val == '0);
      dbz_result = op[0] ? rs1_val : '1;
   end

   // Next-state and datapath control; every register holds by default.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      opb_d     = opb_q;
      acc_d     = acc_q;
      dest_d    = dest_q;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d   = op;
               opb_d  = rs2_val;
               dest_d = rd_addr_in;
               acc_d  = {{XLEN{1'b0}}, rs1_val};
               if (dbz) begin
                  state_d   = DONE;
                  cnt_d     = '0;
                  rd_addr_d = rd_addr_in;
                  rd_data_d = dbz_result;
               end else begin
                  state_d = RUN;
                  cnt_d   = CNT_W'(XLEN);
               end
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               state_d   = DONE;
               rd_addr_d = dest_q;
               rd_data_d = op_q[0] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               acc_d = op_q[1] ? div_next : mul_next;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d      = (state_d != IDLE);
      reg_write_d = (state_d == DONE) && (dest_d != '0);
   end

   // State, operand and result registers; reset drops any in-flight op.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         opb_q       <= '0;
         acc_q       <= '0;
         dest_q      <= '0;
         rd_addr_q   <= '0;
         rd_data_q   <= '0;
         busy_q      <= 1'b0;
         reg_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         opb_q       <= opb_d;
         acc_q       <= acc_d;
         dest_q      <= dest_d;
         rd_addr_q   <= rd_addr_d;
         rd_data_q   <= rd_data_d;
         busy_q      <= busy_d;
         reg_write_q <= reg_write_d;
      end
   end

   assign busy      = busy_q;
   assign reg_write = reg_write_q;
   assign rd_addr   = rd_addr_q;
   assign rd_data   = rd_data_q;

endmodule
